// File: rtl/ifetch.sv
// Instruction fetch stage: owns the fetch PC, issues one imem request at a time and
// feeds decode through a holding register. Define IFETCH_PERF_EN for perf counters.

module ifetch #(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
  input  logic            clk,
  input  logic            resetn,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            imem_resp_err,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr,
  output logic            if_fault,
  output logic [63:0]     perf_fetched,
  output logic [31:0]     perf_stall
);

  localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP   = {{(XLEN-3){1'b0}}, 3'b100};

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              if_valid_q, if_valid_d;
  logic [XLEN-1:0]   if_pc_q, if_pc_d;
  logic [31:0]       if_instr_q, if_instr_d;
  logic              if_fault_q, if_fault_d;
  logic              req_valid_s;
  logic              resp_load_s;
  logic              unused_redirect_lsb_s;

  assign unused_redirect_lsb_s = ^redirect_pc[1:0];

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a response in DRAIN always returns to REQ so a redirect
  // landing on the drained response cannot leave the FSM waiting forever.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_REQ: begin
        if (req_valid_s && imem_req_ready) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (imem_resp_valid) begin
          state_d = ST_REQ;
        end else if (redirect_valid) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        if (imem_resp_valid) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: state_d = ST_REQ;
    endcase
  end

  // FSM outputs: request issue and fresh-response load
  always_comb begin
    req_valid_s = (state_q == ST_REQ) && !redirect_valid && (!if_valid_q || id_ready);
    resp_load_s = (state_q == ST_WAIT) && imem_resp_valid && !redirect_valid;
  end

  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = {pc_q[XLEN-1:2], 2'b00};

  // Fetch PC and decode holding register next-state
  always_comb begin
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if_fault_d = if_fault_q;
    if (redirect_valid) begin
      pc_d       = {redirect_pc[XLEN-1:2], 2'b00};
      if_valid_d = 1'b0;
    end else if (resp_load_s) begin
      pc_d       = pc_q + PC_STEP;
      if_valid_d = 1'b1;
      if_pc_d    = pc_q;
      if_fault_d = imem_resp_err;
      if_instr_d = imem_resp_err ? NOP_INSTR : imem_resp_data;
    end else if (if_valid_q && id_ready) begin
      if_valid_d = 1'b0;
    end else begin
      if_valid_d = if_valid_q;
    end
  end

  // Fetch PC and decode holding register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_pc_q    <= {XLEN{1'b0}};
      if_instr_q <= NOP_INSTR;
      if_fault_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_fault_q <= if_fault_d;
    end
  end

  assign if_valid = if_valid_q;
  assign if_pc    = if_pc_q;
  assign if_instr = if_instr_q;
  assign if_fault = if_fault_q;

`ifdef IFETCH_PERF_EN
  logic [63:0] fetched_q, fetched_d;
  logic [31:0] stall_q, stall_d;

  // Performance counter next-state; both wrap naturally
  always_comb begin
    fetched_d = fetched_q;
    stall_d   = stall_q;
    if (if_valid_q && id_ready) begin
      fetched_d = fetched_q + 64'd1;
    end else if (if_valid_q) begin
      stall_d = stall_q + 32'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  // Performance counters
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetched_q <= 64'd0;
      stall_q   <= 32'd0;
    end else begin
      fetched_q <= fetched_d;
      stall_q   <= stall_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_stall   = stall_q;
`else
  assign perf_fetched = 64'd0;
  assign perf_stall   = 32'd0;
`endif

endmodule

// File: doc/ifetch.md
Name: ifetch

Overview:
- Instruction fetch stage; sits directly upstream of instruction decode and feeds it one 32-bit instruction with its PC per handshake.
- Owns the architectural fetch PC and issues one request at a time on a valid/ready instruction-memory port.
- Accepts redirects (branch/jump target) from later stages and discards stale in-flight responses.
- Holds its output register while decode stalls.

Parameters:
- XLEN, 64, PC/address width.
- RESET_PC, 64'h0 (XLEN bits), first fetch address after reset; bits [1:0] must be 0.

Ports:
- clk  input  1  clock; all state updates on posedge.
- resetn  input  1  asynchronous active-low reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  XLEN  fetch address (word aligned).
- imem_resp_valid  input  1  response valid (single cycle pulse, in order).
- imem_resp_data  input  32  fetched instruction.
- imem_resp_err  input  1  access fault for this response.
- redirect_valid  input  1  redirect fetch to redirect_pc.
- redirect_pc  input  XLEN  new fetch PC; bits [1:0] ignored (treated 0).
- id_ready  input  1  decode accepts if_* this cycle.
- if_valid  output  1  if_pc/if_instr/if_fault valid.
- if_pc  output  XLEN  PC of if_instr.
- if_instr  output  32  instruction to decode.
- if_fault  output  1  fetch access fault flag.
- perf_fetched  output  64  delivered-instruction count (see feature).
- perf_stall  output  32  decode-stall cycle count (see feature).

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (resetn). All flops clear immediately on resetn=0.
- Reset values:
  - pc_q=RESET_PC; state=REQ.
  - if_valid=0, if_pc=0, if_instr=32'h00000013 (NOP), if_fault=0.
  - perf counters=0.
- States:
  - REQ: may issue.
  - WAIT: one request outstanding.
  - DRAIN: outstanding response is stale.
- Request issue:
  - imem_req_valid = (state==REQ) && !redirect_valid && (!if_valid || id_ready).
  - imem_req_addr = {pc_q[XLEN-1:2],2'b00}.
  - Handshake when valid&&ready: state->WAIT.
  - Addr/valid stay stable while waiting for ready unless a redirect occurs.
- Response in WAIT with imem_resp_valid=1:
  - if_valid<=1, if_pc<=pc_q, if_fault<=imem_resp_err.
  - if_instr<=imem_resp_err ? 32'h00000013 : imem_resp_data.
  - pc_q<=pc_q+4, wrapping modulo 2^XLEN.
  - state->REQ.
  - Minimum latency: request handshake at cycle N, response N+1, if_valid visible N+2.
- Response in DRAIN: discarded, outputs untouched, state->REQ.
- Response in REQ: ignored (protocol violation).
- Output consume: if_valid && id_ready clears if_valid next cycle, unless a response loads it the same cycle. Output register never overwritten while if_valid && !id_ready (guaranteed by the issue rule).
- Redirect (priority over everything):
  - pc_q<=redirect_pc with [1:0]=0; if_valid<=0.
  - REQ->REQ; WAIT->DRAIN; DRAIN->DRAIN.
  - If imem_resp_valid arrives in WAIT the same cycle: response discarded, state->REQ (not DRAIN).
  - No request is issued in the redirect cycle.
- Back-to-back redirects: the last one wins; at most one response is ever drained.
- Reset mid-operation: state returns to REQ. Memory-side in-flight responses after reset are the memory's responsibility (reset together).

Optional Feature:
- Macro IFETCH_PERF_EN.
- Defined:
  - perf_fetched increments on each if_valid&&id_ready handshake.
  - perf_stall increments each cycle if_valid&&!id_ready.
  - Both wrap at max.
- Undefined: counters not instantiated; perf_fetched and perf_stall tied to 0. Port list unchanged.

Test Plan:
- Reset, RESET_PC=0x1000, imem ready=1, 1-cycle response, id_ready=1 -> requests at 0x1000,0x1004,0x1008; if_pc matches; one instruction delivered every 2 cycles.
- id_ready=0 with if_valid=1 for 5 cycles -> if_* held stable, imem_req_valid=0; release -> next request 0x1004; perf_stall=5 (with IFETCH_PERF_EN).
- Redirect to 0x2002 while WAIT; stale response arrives next cycle -> discarded, if_valid stays 0, next request addr 0x2000.
- Redirect coincident with response in WAIT -> response dropped, state REQ, next request at redirect target with no DRAIN cycle.
- imem_resp_err=1 at 0x1008 -> if_fault=1, if_instr=0x00000013, if_pc=0x1008; next fetch 0x100C.
- Assert resetn=0 mid-WAIT -> outputs immediately at reset values; after release, first request at RESET_PC.
